// File: rtl/freq_meter_display.sv
// ============================================================================
// Module   : freq_meter_display
// Purpose  : Edge-counting frequency meter with gated and free-running counts,
//            ASCII-hex UART streaming (FREQ_METER_UART_EN) and a 9-digit
//            multiplexed 7-segment display driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_meter_display #(
   parameter int unsigned DEF_UART_DIV = 868,
   parameter int unsigned DEF_PERIOD   = 1000000,
   parameter int unsigned SCAN_CYCLES  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  addr,
   input  logic [31:0] value,
   input  logic        strobe,
   input  logic        samplee,
   output logic [31:0] o,
   output logic [31:0] oc,
   output logic        tx,
   output logic [8:0]  col_drvs,
   output logic [7:0]  seg_drvs
);

   localparam logic [31:0] c_def_period = 32'(DEF_PERIOD);
   localparam logic [31:0] c_scan_last  = 32'(SCAN_CYCLES) - 32'd1;

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [31:0] r_period;
   logic        r_mode;
   logic [31:0] r_digits;
   logic [3:0]  r_digit8;
   logic [8:0]  r_dp;
   logic        w_wr_period;

   assign w_wr_period = strobe && (addr == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_period <= c_def_period;
         r_mode   <= 1'b0;
         r_digits <= 32'd0;
         r_digit8 <= 4'd0;
         r_dp     <= 9'd0;
      end else if (strobe) begin
         case (addr)
            4'd1:    r_period <= (value == 32'd0) ? 32'd1 : value;
            4'd2:    r_mode   <= value[0];
            4'd3:    r_digits <= value;
            4'd4:    r_digit8 <= value[3:0];
            4'd5:    r_dp     <= value[8:0];
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Synchronizer, edge detect, counters
   // ------------------------------------------------------------------
   logic        r_sync1, r_sync2, r_sync2_d;
   logic        w_edge;
   logic [31:0] r_timer, r_gate_cnt;
   logic [31:0] w_meas_val;
   logic        w_gate_end;
   logic        w_new_meas;

   assign w_edge     = r_sync2 & ~r_sync2_d;
   assign w_meas_val = r_gate_cnt + {31'd0, w_edge};
   assign w_gate_end = (r_timer == r_period - 32'd1);
   assign w_new_meas = w_gate_end & ~w_wr_period;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
         oc        <= 32'd0;
      end else begin
         r_sync1   <= samplee;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         oc        <= oc + {31'd0, w_edge};
      end
   end

   // An edge landing in the wrap cycle belongs to the closing period
   always_ff @(posedge clk) begin
      if (reset) begin
         o          <= 32'd0;
         r_timer    <= 32'd0;
         r_gate_cnt <= 32'd0;
      end else if (w_wr_period) begin
         r_timer    <= 32'd0;
         r_gate_cnt <= 32'd0;
      end else if (w_gate_end) begin
         o          <= w_meas_val;
         r_timer    <= 32'd0;
         r_gate_cnt <= 32'd0;
      end else begin
         r_timer    <= r_timer + 32'd1;
         r_gate_cnt <= w_meas_val;
      end
   end

   // ------------------------------------------------------------------
   // UART transmitter
   // ------------------------------------------------------------------
`ifdef FREQ_METER_UART_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   uart_state_t r_state;
   logic [31:0] r_uart_div, r_cur_div, r_clk_cnt;
   logic [31:0] r_snap;
   logic [3:0]  r_byte_idx;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic        w_bit_done;

   function automatic logic [7:0] char_at(input logic [31:0] word, input logic [3:0] idx);
      logic [3:0] nib;
      nib = word[{3'd7 - idx[2:0], 2'b00} +: 4];
      if (idx == 4'd8)
         return 8'h0D;
      else if (idx == 4'd9)
         return 8'h0A;
      else if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

   assign w_bit_done = (r_clk_cnt == r_cur_div - 32'd1);
   assign tx         = r_tx;

   always_ff @(posedge clk) begin
      if (reset)
         r_uart_div <= 32'(DEF_UART_DIV);
      else if (strobe && (addr == 4'd0))
         r_uart_div <= (value < 32'd4) ? 32'd4 : value;
   end

   // Divider is latched per byte so a write lands at the next byte start
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_cur_div  <= 32'(DEF_UART_DIV);
         r_clk_cnt  <= 32'd0;
         r_snap     <= 32'd0;
         r_byte_idx <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_new_meas) begin
                  r_snap     <= w_meas_val;
                  r_byte_idx <= 4'd0;
                  r_shift    <= char_at(w_meas_val, 4'd0);
                  r_cur_div  <= r_uart_div;
                  r_clk_cnt  <= 32'd0;
                  r_tx       <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_clk_cnt <= 32'd0;
                  r_bit_cnt <= 3'd0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  r_clk_cnt <= 32'd0;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_tx      <= r_shift[1];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  r_clk_cnt <= 32'd0;
                  if (r_byte_idx == 4'd9) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_byte_idx <= r_byte_idx + 4'd1;
                     r_shift    <= char_at(r_snap, r_byte_idx + 4'd1);
                     r_cur_div  <= r_uart_div;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
`else
   assign tx = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Display scan
   // ------------------------------------------------------------------
   logic [31:0] r_scan_cnt;
   logic [3:0]  r_col;
   logic [3:0]  w_next_col;
   logic [31:0] w_sel_word;
   logic [3:0]  w_nib;
   logic [7:0]  w_seg;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   always_comb begin
      w_next_col = r_col;
      if (r_scan_cnt == c_scan_last)
         w_next_col = (r_col == 4'd8) ? 4'd0 : r_col + 4'd1;
   end

   assign w_sel_word = r_mode ? r_digits : o;
   assign w_nib      = w_sel_word[{w_next_col[2:0], 2'b00} +: 4];

   always_comb begin
      w_seg = 8'h00;
      if (r_mode)
         w_seg = {r_dp[w_next_col], (w_next_col == 4'd8) ? font(r_digit8) : font(w_nib)};
      else if (w_next_col != 4'd8)
         w_seg = {1'b0, font(w_nib)};
   end

   // Column and pattern are registered together from the same next-column value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= 32'd0;
         r_col      <= 4'd0;
         col_drvs   <= 9'h001;
         seg_drvs   <= 8'h3F;
      end else begin
         r_scan_cnt <= (r_scan_cnt == c_scan_last) ? 32'd0 : r_scan_cnt + 32'd1;
         r_col      <= w_next_col;
         col_drvs   <= 9'h001 << w_next_col;
         seg_drvs   <= w_seg;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_freq_meter_display.sv
// ============================================================================
// Module   : tb_freq_meter_display
// Purpose  : Directed self-checking bench for freq_meter_display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_freq_meter_display;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  addr = 4'd0;
   logic [31:0] value = 32'd0;
   logic        strobe = 1'b0;
   logic        samplee = 1'b0;
   logic [31:0] o, oc;
   logic        tx;
   logic [8:0]  col_drvs;
   logic [7:0]  seg_drvs;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] font_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   freq_meter_display #(
      .DEF_UART_DIV(868),
      .DEF_PERIOD  (1000000),
      .SCAN_CYCLES (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .value   (value),
      .strobe  (strobe),
      .samplee (samplee),
      .o       (o),
      .oc      (oc),
      .tx      (tx),
      .col_drvs(col_drvs),
      .seg_drvs(seg_drvs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      addr = a; value = v; strobe = 1'b1;
      step();
      strobe = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
   endtask

   task automatic gen_edges(input int n);
      for (int i = 0; i < n; i++) begin
         samplee = 1'b1; step(5);
         samplee = 1'b0; step(5);
      end
   endtask

   // Lock onto the column 8 -> 0 transition, then walk all nine columns
   task automatic scan_check(input string tag, input logic mode1);
      logic [8:0] prev;
      logic       found;
      logic [7:0] exp_seg;
      found = 1'b0;
      prev  = col_drvs;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (prev == 9'h100 && col_drvs == 9'h001) found = 1'b1;
         prev = col_drvs;
      end
      if (!found) begin
         chk({tag, "_sync_timeout"}, 32'd0, 32'd1);
      end else begin
         for (int c = 0; c < 9; c++) begin
            if (mode1) exp_seg = (c == 8) ? 8'hFF : font_tbl[c];
            else       exp_seg = (c == 8) ? 8'h00 : 8'h3F;
            chk($sformatf("%s_col%0d", tag, c), {15'd0, col_drvs, seg_drvs}, {15'd0, 9'(1 << c), exp_seg});
            step(4);
         end
      end
   endtask

   task automatic wait_fall(input int limit, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < limit && !ok; k++) begin
         if (tx == 1'b0) ok = 1'b1;
         else step();
      end
   endtask

   task automatic rx_byte(input int div, output logic [7:0] b, output logic [1:0] framing, output logic ok);
      logic st, sp;
      b = 8'h00;
      wait_fall(3000, ok);
      step(div / 2);
      st = tx;
      for (int k = 0; k < 8; k++) begin
         step(div);
         b[k] = tx;
      end
      step(div);
      sp = tx;
      framing = {st, sp};
   endtask

   logic [31:0] oc0, oc_a, sum;
   logic        ok, seen_low;
   logic [7:0]  rb;
   logic [1:0]  fr;
   logic [7:0]  exp_msg [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h41, 8'h0D, 8'h0A};
   int          run;

   initial begin
      // Reset state
      do_reset();
      chk("rst_col", {23'd0, col_drvs}, 32'h001);
      chk("rst_seg", {24'd0, seg_drvs}, 32'h3F);
      step(20);
      chk("rst_o", o, 32'd0);
      chk("rst_oc", oc, 32'd0);
      chk("rst_tx", {31'd0, tx}, 32'd1);

      // Unmapped write must not disturb mode 0 display
      wr(4'd9, 32'hFFFF_FFFF);
      scan_check("mode0", 1'b0);

      // Mode 1 with user digits and dp on column 8
      wr(4'd2, 32'd1);
      wr(4'd3, 32'h7654_3210);
      wr(4'd4, 32'd8);
      wr(4'd5, 32'h100);
      scan_check("mode1", 1'b1);

      // Pin-to-count latency
      samplee = 1'b0; step(5);
      oc0 = oc;
      samplee = 1'b1;
      step(2);
      chk("lat_oc_2cyc", oc, oc0);
      step();
      chk("lat_oc_3cyc", oc, oc0 + 32'd1);
      samplee = 1'b0; step(5);

      // Gate period 100 with a 10-cycle input
      wr(4'd1, 32'd100);
      for (int i = 0; i < 300; i++) begin
         samplee = ((i % 10) < 5);
         if (i == 100) oc_a = oc;
         if (i == 200) chk("oc_delta100", oc - oc_a, 32'd10);
         if (i == 150) chk("gate100_a", o, 32'd10);
         if (i == 250) chk("gate100_b", o, 32'd10);
         step();
      end
      chk("gate100_c", o, 32'd10);
      samplee = 1'b0; step(6);

      // Period 0 behaves as 1: gate every cycle
      wr(4'd1, 32'd0);
      step(5);
      chk("p1_idle", o, 32'd0);
      samplee = 1'b1;
      step(2);
      chk("p1_pre", o, 32'd0);
      step();
      chk("p1_edge", o, 32'd1);
      step();
      chk("p1_post", o, 32'd0);
      samplee = 1'b0; step(6);
      sum = 32'd0;
      for (int i = 0; i < 44; i++) begin
         samplee = (i < 40) && ((i % 10) < 5);
         step();
         sum = sum + o;
      end
      chk("p1_sum40", sum, 32'd4);

`ifdef FREQ_METER_UART_EN
      // Divider clamp: '0' byte gives start + 4 zero data bits low
      do_reset();
      wr(4'd9, 32'hFFFF_FFFF);
      wr(4'd0, 32'd2);
      wr(4'd1, 32'd400);
      gen_edges(26);
      wait_fall(1000, ok);
      chk("uart1_start_seen", {31'd0, ok}, 32'd1);
      run = 0;
      while (tx == 1'b0 && run < 100) begin
         run++;
         step();
      end
      chk("uart_div_clamp", 32'(run), 32'd20);
      // Reset in the middle of byte 1
      wait_fall(200, ok);
      step(2);
      chk("uart_mid_low", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      step();
      chk("uart_abort_tx", {31'd0, tx}, 32'd1);
      chk("uart_abort_o", o, 32'd0);
      chk("uart_abort_oc", oc, 32'd0);
      reset = 1'b0;

      // Full message at 8 clocks per bit
      wr(4'd0, 32'd2);
      wr(4'd0, 32'd8);
      wr(4'd1, 32'd400);
      gen_edges(26);
      for (int j = 0; j < 10; j++) begin
         rx_byte(8, rb, fr, ok);
         chk($sformatf("uart_byte%0d", j), {23'd0, ok, rb}, {23'd1, exp_msg[j]});
         chk($sformatf("uart_frame%0d", j), {30'd0, fr}, 32'b01);
      end
`else
      // No transmitter: tx stays high even across measurements
      wr(4'd0, 32'd2);
      wr(4'd1, 32'd20);
      seen_low = 1'b0;
      for (int i = 0; i < 100; i++) begin
         samplee = ((i % 10) < 5);
         step();
         if (tx == 1'b0) seen_low = 1'b1;
      end
      samplee = 1'b0;
      chk("tx_tied_high", {31'd0, seen_low}, 32'd0);
`endif

      // Final reset returns all outputs
      gen_edges(3);
      do_reset();
      chk("end_o", o, 32'd0);
      chk("end_oc", oc, 32'd0);
      chk("end_tx", {31'd0, tx}, 32'd1);
      chk("end_col", {23'd0, col_drvs}, 32'h001);
      chk("end_seg", {24'd0, seg_drvs}, 32'h3F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
